matrix_scan_driver: RTL and testbench

Parametrised, double-buffered LED-matrix scan driver that replaces the fixed 8x16 display block on the UP2 board. Game logic writes whole rows into a back buffer, then requests a swap that commits only at a frame boundary, so the displayed frame never tears. Adds per-row anti-ghost blanking, PWM brightness and an enable control. Clocked from the fast system clock; no external prescaler is needed.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_scan_timer.sv | 37 +++
 rtl/matrix_scan_driver.sv | 103 ++++++++++
 tb/tb_matrix_scan_driver.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared defaults and helpers for the LED-matrix scan driver
package matrix_pkg;
   localparam int DEF_ROWS       = 8;
   localparam int DEF_COLS       = 16;
   localparam int DEF_ROW_W      = 3;
   localparam int DEF_DIV_W      = 10;
   localparam int DEF_BLANK      = 16;
   localparam int DEF_BRIGHT_W   = 3;
   localparam bit DEF_ACTIVE_LOW = 1'b1;

   // Idle level of every row/column pin: high on active-low boards.
   function automatic logic inactive_level(input bit active_low);
      return active_low;
   endfunction

   function automatic int clog2(input int value);
      int r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
endpackage

// File: rtl/matrix_scan_timer.sv
// rtl/matrix_scan_timer.sv - row/dwell scan counters with frame boundary strobes
module matrix_scan_timer
   import matrix_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int ROW_W = DEF_ROW_W,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [ROW_W-1:0] row_idx,
   output logic [DIV_W-1:0] dwell,
   output logic             frame_start,
   output logic             frame_end
);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [DIV_W-1:0] DWELL_LAST = '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_idx <= '0;
         dwell   <= '0;
      end else if (!enable) begin
         // Held at the origin so re-enable always begins a fresh frame.
         row_idx <= '0;
         dwell   <= '0;
      end else begin
         dwell <= dwell + 1'b1;
         if (dwell == DWELL_LAST)
            row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      end
   end

   assign frame_start = enable && (row_idx == '0) && (dwell == '0);
   assign frame_end   = enable && (row_idx == ROW_LAST) && (dwell == DWELL_LAST);
endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered LED-matrix scan driver with
// tear-free frame-boundary swaps, anti-ghost blanking and PWM brightness
module matrix_scan_driver
   import matrix_pkg::*;
#(
   parameter int ROWS       = DEF_ROWS,
   parameter int COLS       = DEF_COLS,
   parameter int ROW_W      = DEF_ROW_W,
   parameter int DIV_W      = DEF_DIV_W,
   parameter int BLANK      = DEF_BLANK,
   parameter int BRIGHT_W   = DEF_BRIGHT_W,
   parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                wr_en,
   input  logic [ROW_W-1:0]    wr_row,
   input  logic [COLS-1:0]     wr_data,
   input  logic                swap_req,
   input  logic [BRIGHT_W-1:0] brightness,
   output logic                swap_ack,
   output logic                frame_start,
   output logic [ROWS-1:0]     MATRIX_ROW,
   output logic [COLS-1:0]     MATRIX_COL
);
   localparam int               DEPTH    = 2 ** ROW_W;
   localparam logic [ROW_W:0]   ROWS_L   = (ROW_W + 1)'(ROWS);
   localparam logic [DIV_W-1:0] BLANK_L  = DIV_W'(BLANK);
   localparam logic             INACTIVE = inactive_level(ACTIVE_LOW);

   logic [ROW_W-1:0]    row_idx;
   logic [DIV_W-1:0]    dwell;
   logic                frame_start_c;
   logic                frame_end;
   logic [COLS-1:0]     bank [2][DEPTH];
   logic                front;
   logic                pending;
   logic                commit;
   logic [BRIGHT_W-1:0] bright_q;
   logic [BRIGHT_W-1:0] slot;
   logic                lit;
   logic [ROWS-1:0]     row_val;
   logic [COLS-1:0]     col_val;

   matrix_scan_timer #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W),
      .DIV_W (DIV_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .row_idx     (row_idx),
      .dwell       (dwell),
      .frame_start (frame_start_c),
      .frame_end   (frame_end)
   );

   // Disabled display has no frame to tear, so a pending swap commits at once.
   assign commit = pending && (frame_end || !enable);
   assign slot   = dwell[DIV_W-1 -: BRIGHT_W];
   assign lit    = enable && (dwell >= BLANK_L) && (slot <= bright_q);

   always_comb begin
      row_val = '0;
      col_val = '0;
      if (enable) row_val = ROWS'(1) << row_idx;
      if (lit)    col_val = bank[front][row_idx];
   end

   // Writes target the bank that is back before any swap committing this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            bank[0][r] <= '0;
            bank[1][r] <= '0;
         end
      end else if (wr_en && ({1'b0, wr_row} < ROWS_L)) begin
         bank[~front][wr_row] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         front       <= 1'b0;
         pending     <= 1'b0;
         bright_q    <= '0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
         MATRIX_ROW  <= {ROWS{INACTIVE}};
         MATRIX_COL  <= {COLS{INACTIVE}};
      end else begin
         front       <= front ^ commit;
         pending     <= swap_req || (pending && !commit);
         if (dwell == '0) bright_q <= brightness;
         swap_ack    <= commit;
         frame_start <= frame_start_c;
         MATRIX_ROW  <= row_val ^ {ROWS{INACTIVE}};
         MATRIX_COL  <= col_val ^ {COLS{INACTIVE}};
      end
   end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - scoreboard bench for matrix_scan_driver
// (ROWS=4, COLS=8, ROW_W=3, DIV_W=4, BLANK=2, BRIGHT_W=2, active-low)
module tb_matrix_scan_driver;
   localparam int ROWS = 4, COLS = 8, ROW_W = 3, DIV_W = 4, BLANK = 2, BRIGHT_W = 2;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                enable = 1'b1;
   logic                wr_en = 1'b0;
   logic [ROW_W-1:0]    wr_row = '0;
   logic [COLS-1:0]     wr_data = '0;
   logic                swap_req = 1'b0;
   logic [BRIGHT_W-1:0] brightness = 2'd3;
   logic                swap_ack;
   logic                frame_start;
   logic [ROWS-1:0]     MATRIX_ROW;
   logic [COLS-1:0]     MATRIX_COL;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [3:0] row;
      logic [7:0] col;
      logic       ack;
      logic       fs;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_bank [2][4];
   logic       m_front, m_pending;
   logic [1:0] m_bq;
   logic [1:0] m_row;
   logic [3:0] m_dwell;
   int         last_pos;

   always #5 clk = ~clk;

   matrix_scan_driver #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .ROW_W      (ROW_W),
      .DIV_W      (DIV_W),
      .BLANK      (BLANK),
      .BRIGHT_W   (BRIGHT_W),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .brightness  (brightness),
      .swap_ack    (swap_ack),
      .frame_start (frame_start),
      .MATRIX_ROW  (MATRIX_ROW),
      .MATRIX_COL  (MATRIX_COL)
   );

   task automatic model_reset();
      for (int r = 0; r < 4; r++) begin
         m_bank[0][r] = 8'h00;
         m_bank[1][r] = 8'h00;
      end
      m_front   = 1'b0;
      m_pending = 1'b0;
      m_bq      = 2'd0;
      m_row     = 2'd0;
      m_dwell   = 4'd0;
   endtask

   // Predicts the registered outputs for the current counter state, pushes
   // them, advances the model, and clocks the DUT once.
   task automatic cycle();
      exp_t e;
      logic lit, commit;
      lit    = enable && (m_dwell >= 4'(BLANK)) && (m_dwell[3:2] <= m_bq);
      e.row  = enable ? ~(4'b0001 << m_row) : 4'hF;
      e.col  = lit ? ~m_bank[m_front][m_row] : 8'hFF;
      e.fs   = enable && (m_row == 2'd0) && (m_dwell == 4'd0);
      commit = m_pending && (!enable || (m_row == 2'd3 && m_dwell == 4'd15));
      e.ack  = commit;
      exp_q.push_back(e);
      last_pos = int'({m_row, m_dwell});
      if (wr_en && wr_row < 3'(ROWS)) m_bank[!m_front][wr_row[1:0]] = wr_data;
      m_pending = swap_req || (m_pending && !commit);
      if (commit) m_front = !m_front;
      if (m_dwell == 4'd0) m_bq = brightness;
      if (!enable) begin
         m_row   = 2'd0;
         m_dwell = 4'd0;
      end else begin
         if (m_dwell == 4'd15) m_row = m_row + 2'd1;
         m_dwell = m_dwell + 4'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      @(posedge clk);
      #1;
      tests++;
      if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_idle got=%h expected=%h", {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, {4'hF, 8'hFF, 2'b00});
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 40; i++) begin
         cycle();
         e = exp_q.pop_front();
         tests++;
         if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
            fails++;
            $display("FAIL reset_scan pos=%0d got=%h expected=%h", last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
         end
      end
      tests++;
      if (MATRIX_ROW !== 4'hB) begin
         fails++;
         $display("FAIL row2_active got=%h expected=b", MATRIX_ROW);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({MATRIX_ROW, MATRIX_COL} !== {4'hF, 8'hFF}) begin
         fails++;
         $display("FAIL reset_async got=%h expected=fff", {MATRIX_ROW, MATRIX_COL});
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (frame_start !== 1'b1 || MATRIX_ROW !== 4'hE || {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
         fails++;
         $display("FAIL reset_restart fs=%b row=%h expected fs=1 row=e", frame_start, MATRIX_ROW);
      end
   endtask

   task automatic test_swap();
      exp_t e;
      int acks = 0, ack_pos = -1;
      wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'hA5;
      cycle();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      while (last_pos != 4) begin
         cycle();
         e = exp_q.pop_front();
      end
      swap_req = 1'b1;
      cycle();
      swap_req = 1'b0;
      e = exp_q.pop_front();
      do begin
         cycle();
         e = exp_q.pop_front();
         tests++;
         if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
            fails++;
            $display("FAIL swap_scan pos=%0d got=%h expected=%h", last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
         end
         if (swap_ack === 1'b1) begin
            acks++;
            ack_pos = last_pos;
         end
         if (last_pos == 21) begin
            tests++;
            if (MATRIX_COL !== 8'hFF) begin
               fails++;
               $display("FAIL pre_swap_row1 got=%h expected=ff", MATRIX_COL);
            end
         end
      end while (last_pos != 63);
      tests++;
      if (acks != 1 || ack_pos != 63) begin
         fails++;
         $display("FAIL swap_ack_timing acks=%0d at=%0d expected 1 at 63", acks, ack_pos);
      end
      do begin
         cycle();
         e = exp_q.pop_front();
         if (last_pos == 21) begin
            tests++;
            if (MATRIX_COL !== 8'h5A) begin
               fails++;
               $display("FAIL post_swap_row1 got=%h expected=5a", MATRIX_COL);
            end
         end
      end while (last_pos != 63);
   endtask

   task automatic test_brightness();
      exp_t e;
      logic [7:0] want;
      wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hFF; swap_req = 1'b1;
      cycle();
      wr_en = 1'b0; swap_req = 1'b0;
      e = exp_q.pop_front();
      do begin
         cycle();
         e = exp_q.pop_front();
      end while (last_pos != 63);
      for (int b = 0; b < 2; b++) begin
         brightness = (b == 0) ? 2'd1 : 2'd3;
         do begin
            cycle();
            e = exp_q.pop_front();
            tests++;
            if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
               fails++;
               $display("FAIL bright_scan b=%0d pos=%0d got=%h expected=%h", brightness, last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
            end
            if (last_pos < 16) begin
               want = (last_pos >= 2 && last_pos <= ((b == 0) ? 7 : 15)) ? 8'h00 : 8'hFF;
               tests++;
               if (MATRIX_COL !== want) begin
                  fails++;
                  $display("FAIL bright_level b=%0d dwell=%0d got=%h expected=%h", brightness, last_pos, MATRIX_COL, want);
               end
            end
         end while (last_pos != 63);
      end
   endtask

   task automatic test_coalesce();
      exp_t e;
      int acks = 0, nxt;
      for (int f = 0; f < 2; f++) begin
         do begin
            nxt = (last_pos + 1) % 64;
            swap_req = (f == 0) && (nxt == 3 || nxt == 10 || nxt == 40);
            cycle();
            swap_req = 1'b0;
            e = exp_q.pop_front();
            tests++;
            if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
               fails++;
               $display("FAIL coalesce_scan pos=%0d got=%h expected=%h", last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
            end
            if (swap_ack === 1'b1) acks++;
            if (f == 1 && last_pos == 21 && MATRIX_COL !== 8'h5A) begin
               fails++;
               $display("FAIL coalesce_bank row1 got=%h expected=5a", MATRIX_COL);
            end
         end while (last_pos != 63);
      end
      tests++;
      if (acks != 1) begin
         fails++;
         $display("FAIL coalesce_acks got=%0d expected=1", acks);
      end
   endtask

   task automatic test_disable();
      exp_t e;
      while (last_pos != 19) begin
         cycle();
         e = exp_q.pop_front();
      end
      swap_req = 1'b1;
      cycle();
      swap_req = 1'b0;
      e = exp_q.pop_front();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         e = exp_q.pop_front();
         tests++;
         if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== {4'hF, 8'hFF, (i == 0), 1'b0} ||
             {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
            fails++;
            $display("FAIL disable_cycle%0d got=%h expected=%h", i, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         e = exp_q.pop_front();
         tests++;
         if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
            fails++;
            $display("FAIL reenable_scan pos=%0d got=%h expected=%h", last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
         end
         if (i == 0 && (frame_start !== 1'b1 || MATRIX_ROW !== 4'hE)) begin
            fails++;
            $display("FAIL reenable_fs fs=%b row=%h expected fs=1 row=e", frame_start, MATRIX_ROW);
         end
         if (i == 2 && MATRIX_COL !== 8'h00) begin
            fails++;
            $display("FAIL reenable_bank got=%h expected=00", MATRIX_COL);
         end
      end
   endtask

   task automatic test_bad_row();
      exp_t e;
      int lit_cnt = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
      wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'hFF;
      cycle();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      swap_req = 1'b1;
      cycle();
      swap_req = 1'b0;
      e = exp_q.pop_front();
      for (int f = 0; f < 2; f++) begin
         do begin
            cycle();
            e = exp_q.pop_front();
            tests++;
            if ({MATRIX_ROW, MATRIX_COL, swap_ack, frame_start} !== e) begin
               fails++;
               $display("FAIL bad_row_scan pos=%0d got=%h expected=%h", last_pos, {MATRIX_ROW, MATRIX_COL, swap_ack, frame_start}, e);
            end
            if (f == 1 && MATRIX_COL !== 8'hFF) lit_cnt++;
         end while (last_pos != 63);
      end
      tests++;
      if (lit_cnt != 0) begin
         fails++;
         $display("FAIL bad_row_dark lit_cycles=%0d expected=0", lit_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_swap();
      test_brightness();
      test_coalesce();
      test_disable();
      test_bad_row();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
